// File: rtl/adma_sm_axi_b.sv
// AXI B-channel response generator: pairs queued AW info with W-done events in
// order and presents one registered B response per transaction.
module adma_sm_axi_b #(
  parameter int SLV_ID_W     = 5,
  parameter int ATX_RESP_W   = 2,
  parameter int ATX_NUM_OSTD = 4,
  parameter int OSTD_CNT_W   = $clog2(ATX_NUM_OSTD + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SLV_ID_W-1:0]   aw_id,
  input  logic                  aw_decerr,
  input  logic                  aw_vld,
  output logic                  aw_rdy,
  input  logic                  wd_slverr,
  input  logic                  wd_vld,
  output logic                  wd_rdy,
  output logic [SLV_ID_W-1:0]   s_bid_o,
  output logic [ATX_RESP_W-1:0] s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  output logic [OSTD_CNT_W-1:0] ostd_cnt
);

  localparam int PTR_W = $clog2(ATX_NUM_OSTD);
  localparam int AWE_W = SLV_ID_W + 1;

  // DECERR outranks SLVERR; EXOKAY is never produced.
  function automatic logic [ATX_RESP_W-1:0] resp_encode(input logic decerr, input logic slverr);
    logic [ATX_RESP_W-1:0] r;
    r = '0;
    if (decerr)      r[1:0] = 2'b11;
    else if (slverr) r[1:0] = 2'b10;
    return r;
  endfunction

  logic [AWE_W-1:0]      r_aw_mem [ATX_NUM_OSTD];
  logic                  r_wd_mem [ATX_NUM_OSTD];
  logic [PTR_W:0]        r_aw_wptr, r_aw_rptr, r_wd_wptr, r_wd_rptr;
  logic                  r_bvalid_p1;
  logic [SLV_ID_W-1:0]   r_bid_p1;
  logic [ATX_RESP_W-1:0] r_bresp_p1;
  logic [OSTD_CNT_W-1:0] r_ostd_cnt;

  logic             w_aw_full, w_aw_empty, w_wd_full, w_wd_empty;
  logic             w_aw_push, w_wd_push, w_pair, w_b_hs;
  logic [AWE_W-1:0] w_aw_head;
  logic             w_wd_head;

  assign w_aw_full  = (r_aw_wptr[PTR_W] != r_aw_rptr[PTR_W]) &&
                      (r_aw_wptr[PTR_W-1:0] == r_aw_rptr[PTR_W-1:0]);
  assign w_aw_empty = (r_aw_wptr == r_aw_rptr);
  assign w_wd_full  = (r_wd_wptr[PTR_W] != r_wd_rptr[PTR_W]) &&
                      (r_wd_wptr[PTR_W-1:0] == r_wd_rptr[PTR_W-1:0]);
  assign w_wd_empty = (r_wd_wptr == r_wd_rptr);

  assign aw_rdy    = ~w_aw_full;
  assign wd_rdy    = ~w_wd_full;
  assign w_aw_push = aw_vld & ~w_aw_full;
  assign w_wd_push = wd_vld & ~w_wd_full;
  assign w_b_hs    = r_bvalid_p1 & s_bready_i;
  assign w_pair    = ~w_aw_empty & ~w_wd_empty & (~r_bvalid_p1 | s_bready_i);
  assign w_aw_head = r_aw_mem[r_aw_rptr[PTR_W-1:0]];
  assign w_wd_head = r_wd_mem[r_wd_rptr[PTR_W-1:0]];

  // Stage p0: queue storage and pointers
  always_ff @(posedge clk) begin
    if (w_aw_push) r_aw_mem[r_aw_wptr[PTR_W-1:0]] <= {aw_id, aw_decerr};
    if (w_wd_push) r_wd_mem[r_wd_wptr[PTR_W-1:0]] <= wd_slverr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_wptr <= '0;
      r_aw_rptr <= '0;
      r_wd_wptr <= '0;
      r_wd_rptr <= '0;
    end else begin
      if (w_aw_push) r_aw_wptr <= r_aw_wptr + 1'b1;
      if (w_wd_push) r_wd_wptr <= r_wd_wptr + 1'b1;
      if (w_pair) begin
        r_aw_rptr <= r_aw_rptr + 1'b1;
        r_wd_rptr <= r_wd_rptr + 1'b1;
      end
    end
  end

  // Stage p1: B output register, reloadable in the cycle it is drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid_p1 <= 1'b0;
      r_bid_p1    <= '0;
      r_bresp_p1  <= '0;
    end else if (w_pair) begin
      r_bvalid_p1 <= 1'b1;
      r_bid_p1    <= w_aw_head[AWE_W-1:1];
      r_bresp_p1  <= resp_encode(w_aw_head[0], w_wd_head);
    end else if (w_b_hs) begin
      r_bvalid_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ostd_cnt <= '0;
    end else begin
      unique case ({w_aw_push, w_b_hs})
        2'b10:   r_ostd_cnt <= r_ostd_cnt + OSTD_CNT_W'(1);
        2'b01:   r_ostd_cnt <= r_ostd_cnt - OSTD_CNT_W'(1);
        default: r_ostd_cnt <= r_ostd_cnt;
      endcase
    end
  end

  assign s_bvalid_o = r_bvalid_p1;
  assign s_bid_o    = r_bid_p1;
  assign s_bresp_o  = r_bresp_p1;
  assign ostd_cnt   = r_ostd_cnt;

endmodule

// File: doc/adma_sm_axi_b.md
Name: adma_sm_axi_b

Overview:
- AXI write-response (B channel) generator for the slave side of the DMA datapath; it is the transmitter counterpart of the master-side B receiver.
- Pairs each accepted write address (AWID plus a decode-error flag) with the matching write-data completion event (WLAST accepted plus a slave-error flag).
- Emits exactly one in-order B response per transaction through a registered valid/ready output stage.
- Sits between the slave AW/W front-end and the AXI B channel toward the interconnect.

Parameters:
- SLV_ID_W, 5, width of AWID/BID.
- ATX_RESP_W, 2, width of BRESP; fixed at 2 and not configurable in practice.
- ATX_NUM_OSTD, 4, depth of both the AW-info queue and the W-done queue (max outstanding writes); must be a power of 2 and at least 2.
- OSTD_CNT_W, $clog2(ATX_NUM_OSTD+1), derived width of the outstanding counter; do not configure.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- aw_id  input  SLV_ID_W  AWID of the accepted write address
- aw_decerr  input  1  address decoded to no target
- aw_vld  input  1  AW info valid
- aw_rdy  output  1  AW queue not full
- wd_slverr  input  1  target flagged an error on any beat of the burst
- wd_vld  input  1  W burst complete (WLAST accepted)
- wd_rdy  output  1  W-done queue not full
- s_bid_o  output  SLV_ID_W  BID
- s_bresp_o  output  ATX_RESP_W  BRESP
- s_bvalid_o  output  1  BVALID
- s_bready_i  input  1  BREADY
- ostd_cnt  output  OSTD_CNT_W  number of AW entries accepted but not yet answered on B

Behaviour:
- Reset values (async, rst_n=0): both queues empty, s_bvalid_o=0, s_bid_o=0, s_bresp_o=0, ostd_cnt=0, aw_rdy=1, wd_rdy=1.
- A reset asserted mid-operation flushes all queue contents and any pending B response immediately; nothing is emitted after reset release.
- AW queue:
  - FIFO of {aw_id, aw_decerr}; push when aw_vld & aw_rdy.
  - aw_rdy = ~full, purely from registered state; no combinational path from aw_vld.
  - A push at full is not possible; a push at full in the same cycle as a pop is still refused.
- W-done queue:
  - FIFO of wd_slverr; push when wd_vld & wd_rdy; wd_rdy = ~full.
  - W completion may arrive before its AW (AXI permits this). Pairing is strictly in order: the Nth W-done pairs with the Nth AW.
- Pairing (pop both heads in the same cycle) when all hold:
  - both queues are non-empty, and
  - the output register is empty, or is being drained this cycle (s_bvalid_o & s_bready_i).
- Response encoding on pairing:
  - aw_decerr=1 gives BRESP=2'b11 (DECERR) regardless of wd_slverr.
  - Otherwise wd_slverr=1 gives 2'b10 (SLVERR).
  - Otherwise 2'b00 (OKAY). EXOKAY (2'b01) is never generated.
- Output register:
  - Loaded on pairing; s_bvalid_o is set the next cycle.
  - Minimum latency: 1 cycle from the later of the two pushes becoming visible at the queue heads. Each queue has 1-cycle write-to-read latency, so a simultaneous push to both empty queues at cycle T gives s_bvalid_o=1 at T+2.
  - s_bid_o and s_bresp_o stay stable while s_bvalid_o=1 and s_bready_i=0.
  - s_bvalid_o clears after the handshake unless a new pairing reloads it in the same cycle.
  - Full throughput: one B response per cycle when bready is held high.
- ostd_cnt:
  - +1 on AW push, -1 on B handshake; both in the same cycle leaves it unchanged.
  - Range 0..ATX_NUM_OSTD+1 (queue plus output register).
- Wrap-around: queue pointers are ATX_NUM_OSTD-modulo with an extra wrap bit for full/empty detection.
- Protocol errors:
  - A W-done with no AW ever arriving stalls indefinitely; this is not an error to detect.
  - A W-done push while wd_rdy=0 is ignored (caller bug).

Test Plan:
- Single write: AW{id=5'h03, decerr=0} and WD{slverr=0} pushed at cycle 0, bready=1 -> s_bvalid_o=1 at cycle 2 with BID=3, BRESP=00, then drops; ostd_cnt goes 1→0.
- W before AW: WD{slverr=1} at cycle 0, AW{id=5'h0A} at cycle 5 -> single B with BID=0x0A, BRESP=10, at cycle 7.
- Decode error priority: AW{id=1, decerr=1} with WD{slverr=1} -> BRESP=11.
- Backpressure and full:
  - Push 4 AW (ids 1..4) and 4 WD with bready=0 -> one response held in the output register and aw_rdy returns to 1.
  - Push 1 more AW/WD pair -> aw_rdy=0 and wd_rdy=0, ostd_cnt=5.
  - Raise bready -> BIDs 1..5 appear in order on consecutive cycles with BID/BRESP stable while stalled.
- Reset mid-operation: 3 AW and 2 WD pending with s_bvalid_o=1, assert rst_n=0 -> all outputs return to reset values immediately; after release, no stale B appears and a new single write completes normally.
- Streaming: continuous AW/WD pairs with random slverr and bready=1 -> one B per cycle sustained; BRESP matches each pair's slverr; total B count equals total AW count.
